code_loader_uart: RTL and testbench

- Upstream feeder of the code-memory instruction bus. Receives a program image over a UART line and writes it word-by-word into code memory.
- Holds the CPU in reset while loading; the top level ORs oCPUHold into the CPU reset.
- Lets the team reload programs without resynthesising the memory init file.

---
 rtl/code_loader_uart.sv | 253 +++++++++++++++++++++++++
 tb/tb_code_loader_uart.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_loader_uart.sv
// UART program loader: decodes framed program images from iRxD and writes them
// word-by-word into code memory while holding the CPU in reset.
module code_loader_uart #(
  parameter int unsigned CLK_FREQ       = 50000000,
  parameter int unsigned BAUD           = 115200,
  parameter logic [63:0] ADDR_BASE      = 64'h0000_0000_0040_0000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 16 * (CLK_FREQ / BAUD) * 10
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRxD,
  input  logic        iEnable,
  output logic        oCPUHold,
  output logic        oIwWriteEnable,
  output logic [3:0]  oIwByteEnable,
  output logic [63:0] oIwAddress,
  output logic [63:0] oIwWriteData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError,
  output logic [15:0] oWordCount
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_LAST    = 32'(HALF_BIT - 1);
  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  // ---------------- UART receiver ----------------
  rx_state_t   r_rx_state, w_rx_next;
  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  logic [31:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_byte_valid, r_frame_err;
  logic [7:0]  r_byte;
  logic        w_bit_tick, w_half_tick;

  assign w_bit_tick  = (r_rx_cnt == BIT_LAST);
  assign w_half_tick = (r_rx_cnt == HALF_LAST);

  // Synchroniser flops reset to the idle-high line level so reset release
  // never looks like a start bit.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value, which is what makes this a real two-stage synchroniser.
      r_rx_meta <= iRxD;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_rx_next = r_rx_state;
    unique case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
      RX_START: if (w_half_tick) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_bit_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_next;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte       <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      unique case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end
        RX_START: r_rx_cnt <= w_half_tick ? '0 : r_rx_cnt + 32'd1;
        RX_DATA: begin
          if (w_bit_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 32'd1;
          end
        end
        RX_STOP: begin
          if (w_bit_tick) begin
            r_rx_cnt <= '0;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_rx_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 32'd1;
          end
        end
        default: r_rx_cnt <= '0;
      endcase
    end
  end

  // ---------------- Frame loader ----------------
  state_t      r_state, w_state_next;
  logic [7:0]  r_count_lo;
  logic [15:0] r_count_n;
  logic [31:0] r_word;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_chk;
  logic [15:0] r_word_count;
  logic [31:0] r_idle_cnt;
  logic        r_we, r_hold, r_busy, r_done, r_error;
  logic [63:0] r_addr, r_wdata;

  logic        w_in_frame, w_timeout, w_abort, w_n_bad, w_word_done, w_last_word;
  logic        w_start, w_enter_done, w_enter_err;
  logic [15:0] w_n_rx;

  assign w_in_frame  = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                       (r_state == S_DATA)   || (r_state == S_CHK);
  assign w_timeout   = (r_idle_cnt >= TIMEOUT_CYCLES);
  assign w_abort     = w_in_frame && (!iEnable || r_frame_err || w_timeout);
  assign w_n_rx      = {r_byte, r_count_lo};
  assign w_n_bad     = (w_n_rx == 16'd0) || (32'(w_n_rx) > MAX_WORDS);
  assign w_word_done = (r_state == S_DATA) && r_byte_valid && (r_byte_idx == 2'd3) && !w_abort;
  assign w_last_word = ((r_word_count + 16'd1) == r_count_n);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (r_byte_valid && r_byte == SYNC_BYTE && iEnable) w_state_next = S_CNT_LO;
      S_CNT_LO: if (r_byte_valid) w_state_next = S_CNT_HI;
      S_CNT_HI: if (r_byte_valid) w_state_next = w_n_bad ? S_ERROR : S_DATA;
      S_DATA:   if (w_word_done && w_last_word) w_state_next = S_CHK;
      S_CHK:    if (r_byte_valid) w_state_next = (r_byte == r_chk) ? S_DONE : S_ERROR;
      S_DONE:   w_state_next = S_IDLE;
      S_ERROR:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (w_abort) w_state_next = S_ERROR;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  assign w_start      = (r_state == S_IDLE) && (w_state_next == S_CNT_LO);
  assign w_enter_done = (r_state == S_CHK) && (w_state_next == S_DONE);
  assign w_enter_err  = (r_state != S_ERROR) && (w_state_next == S_ERROR);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_count_lo   <= '0;
      r_count_n    <= '0;
      r_word       <= '0;
      r_byte_idx   <= '0;
      r_chk        <= '0;
      r_word_count <= '0;
      r_idle_cnt   <= '0;
      r_we         <= 1'b0;
      r_hold       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_addr       <= ADDR_BASE;
      r_wdata      <= '0;
    end else begin
      r_we <= 1'b0;

      if (w_start || r_byte_valid || !w_in_frame) r_idle_cnt <= '0;
      else                                        r_idle_cnt <= r_idle_cnt + 32'd1;

      if (w_start) begin
        r_hold       <= 1'b1;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_error      <= 1'b0;
        r_word_count <= '0;
        r_chk        <= '0;
        r_byte_idx   <= '0;
      end

      if (r_byte_valid && !w_abort) begin
        unique case (r_state)
          S_CNT_LO: r_count_lo <= r_byte;
          S_CNT_HI: r_count_n  <= w_n_rx;
          S_DATA: begin
            // Bytes enter at the top, so after four shifts byte k sits at [8k+7:8k].
            r_word     <= {r_byte, r_word[31:8]};
            r_chk      <= r_chk ^ r_byte;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
          default: ;
        endcase
      end

      if (w_word_done) begin
        r_we         <= 1'b1;
        r_addr       <= ADDR_BASE + {46'd0, r_word_count, 2'b00};
        r_wdata      <= {32'd0, r_byte, r_word[31:8]};
        r_word_count <= r_word_count + 16'd1;
      end

      if (w_enter_done) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_hold <= 1'b0;
      end

      // Hold stays asserted on error: code memory is only partly overwritten.
      if (w_enter_err) begin
        r_error <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  assign oCPUHold       = r_hold;
  assign oIwWriteEnable = r_we;
  assign oIwByteEnable  = 4'b1111;
  assign oIwAddress     = r_addr;
  assign oIwWriteData   = r_wdata;
  assign oBusy          = r_busy;
  assign oDone          = r_done;
  assign oError         = r_error;
  assign oWordCount     = r_word_count;

endmodule

// File: tb/tb_code_loader_uart.sv
// Randomised self-checking bench for code_loader_uart: bytes are serialised onto
// iRxD and the outputs are compared against a frame-level reference model.
module tb_code_loader_uart;

  localparam int          CPB  = 4;
  localparam logic [63:0] BASE = 64'h0000_0000_0040_0000;
  localparam int          TMO  = 16 * CPB * 10;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iRxD = 1'b1;
  logic        iEnable = 1'b0;
  logic        oCPUHold, oIwWriteEnable, oBusy, oDone, oError;
  logic [3:0]  oIwByteEnable;
  logic [63:0] oIwAddress, oIwWriteData;
  logic [15:0] oWordCount;

  code_loader_uart #(.CLK_FREQ(400), .BAUD(100)) dut (
    .iCLK(iCLK), .iRST(iRST), .iRxD(iRxD), .iEnable(iEnable),
    .oCPUHold(oCPUHold), .oIwWriteEnable(oIwWriteEnable),
    .oIwByteEnable(oIwByteEnable), .oIwAddress(oIwAddress),
    .oIwWriteData(oIwWriteData), .oBusy(oBusy), .oDone(oDone),
    .oError(oError), .oWordCount(oWordCount)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: records every strobe cycle and the longest strobe run.
  logic [63:0] obs_addr[$], obs_data[$];
  int we_run = 0, we_max = 0;
  always @(negedge iCLK) begin
    if (oIwWriteEnable) begin
      obs_addr.push_back(oIwAddress);
      obs_data.push_back(oIwWriteData);
      we_run++;
      if (we_run > we_max) we_max = we_run;
    end else begin
      we_run = 0;
    end
  end

  // Frame-level reference model.
  int          m_phase;   // 0 idle, 1 count lo, 2 count hi, 3 payload, 4 checksum
  int          m_k;
  logic [15:0] m_n, m_wc;
  logic [7:0]  m_lo, m_chk;
  logic [31:0] m_word;
  bit          m_hold, m_done, m_err, m_busy;
  logic [63:0] exp_addr[$], exp_data[$];

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_n = 0; m_wc = 0; m_lo = 0; m_chk = 0; m_word = 0;
    m_hold = 0; m_done = 0; m_err = 0; m_busy = 0;
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic model_fail();
    m_err = 1; m_busy = 0; m_phase = 0;
  endtask

  task automatic model_abort();
    if (m_busy) model_fail();
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_phase)
      0: if (b == 8'hA5 && iEnable) begin
           m_phase = 1; m_busy = 1; m_hold = 1; m_done = 0; m_err = 0; m_wc = 0; m_chk = 0;
         end
      1: begin m_lo = b; m_phase = 2; end
      2: begin
           m_n = {b, m_lo};
           if (m_n == 0 || m_n > 4096) model_fail();
           else begin m_phase = 3; m_k = 0; end
         end
      3: begin
           m_chk ^= b;
           m_word[8*m_k +: 8] = b;
           m_k++;
           if (m_k == 4) begin
             exp_addr.push_back(BASE + 64'(m_wc) * 64'd4);
             exp_data.push_back({32'd0, m_word});
             m_wc++;
             m_k = 0;
             if (m_wc == m_n) m_phase = 4;
           end
         end
      4: if (b == m_chk) begin m_done = 1; m_busy = 0; m_hold = 0; m_phase = 0; end
         else model_fail();
      default: m_phase = 0;
    endcase
  endtask

  // Serial driver: 8N1, then one idle bit time.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    iRxD = 1'b0;
    repeat (CPB) @(negedge iCLK);
    for (int i = 0; i < 8; i++) begin
      iRxD = b[i];
      repeat (CPB) @(negedge iCLK);
    end
    iRxD = stop_ok;
    repeat (CPB) @(negedge iCLK);
    iRxD = 1'b1;
    repeat (CPB) @(negedge iCLK);
    if (stop_ok) model_byte(b);
    else         model_abort();
  endtask

  logic [7:0] txq[$];

  task automatic send_txq();
    while (txq.size() > 0) send_byte(txq.pop_front(), 1'b1);
  endtask

  task automatic make_frame(input int n, input bit bad_chk);
    logic [15:0] nn;
    logic [7:0]  c, b;
    nn = 16'(n);
    c  = 8'h00;
    txq.push_back(8'hA5);
    txq.push_back(nn[7:0]);
    txq.push_back(nn[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      c ^= b;
      txq.push_back(b);
    end
    txq.push_back(bad_chk ? (c ^ 8'(1 + $urandom_range(0, 254))) : c);
  endtask

  task automatic compare_state(input string tag);
    repeat (4) @(negedge iCLK);
    check({tag, "_done"}, oDone, m_done);
    check({tag, "_err"}, oError, m_err);
    check({tag, "_hold"}, oCPUHold, m_hold);
    check({tag, "_busy"}, oBusy, m_busy);
    check({tag, "_wc"}, oWordCount, m_wc);
    check({tag, "_nwr"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
    end
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hold"}, oCPUHold, 1'b0);
    check({tag, "_we"}, oIwWriteEnable, 1'b0);
    check({tag, "_be"}, oIwByteEnable, 4'b1111);
    check({tag, "_addr"}, oIwAddress, BASE);
    check({tag, "_data"}, oIwWriteData, 64'd0);
    check({tag, "_busy"}, oBusy, 1'b0);
    check({tag, "_done"}, oDone, 1'b0);
    check({tag, "_err"}, oError, 1'b0);
    check({tag, "_wc"}, oWordCount, 16'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    model_reset();
    repeat (3) @(negedge iCLK);
    check_reset_values("reset");
    iRST = 1'b1;
    iEnable = 1'b1;
    repeat (5) @(negedge iCLK);

    // Two-word frame with correct and then incorrect checksum.
    txq = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h00, 8'h80, 8'hD2,
            8'h41, 8'h00, 8'h00, 8'h8B, 8'hB8};
    we_max = 0;
    send_txq();
    compare_state("good2");
    check("strobe_width", we_max, 1);
    txq = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h00, 8'h80, 8'hD2,
            8'h41, 8'h00, 8'h00, 8'h8B, 8'hB9};
    send_txq();
    compare_state("badchk");

    // Zero and oversize counts, then a one-word frame releasing the CPU.
    txq = '{8'hA5, 8'h00, 8'h00};
    send_txq();
    compare_state("n0");
    txq = '{8'hA5, 8'h01, 8'h10};
    send_txq();
    compare_state("nmax");
    txq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_txq();
    compare_state("one");

    // Framing error on the third payload byte.
    txq = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h00};
    send_txq();
    send_byte(8'h80, 1'b0);
    compare_state("frame");

    // Inter-byte timeout after the count bytes.
    txq = '{8'hA5, 8'h01, 8'h00};
    send_txq();
    repeat (TMO - 40) @(negedge iCLK);
    check("tmo_early", oError, 1'b0);
    waited = 0;
    while (!oError && waited < 100) begin
      @(negedge iCLK);
      waited++;
    end
    check("tmo_fired", oError, 1'b1);
    model_abort();
    compare_state("tmo");

    // Enable dropped mid-payload.
    txq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02};
    send_txq();
    iEnable = 1'b0;
    @(negedge iCLK);
    check("en_drop_err", oError, 1'b1);
    model_abort();
    iEnable = 1'b1;
    compare_state("en_drop");

    // One-cycle glitch immediately before a real frame.
    iRxD = 1'b0;
    @(negedge iCLK);
    iRxD = 1'b1;
    repeat (8) @(negedge iCLK);
    check("glitch_busy", oBusy, 1'b0);
    make_frame(1, 1'b0);
    send_txq();
    compare_state("glitch");

    // Asynchronous reset in the middle of the payload.
    txq = '{8'hA5, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
    send_txq();
    compare_state("pre_rst");
    #2 iRST = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    repeat (3) @(negedge iCLK);
    iRST = 1'b1;
    repeat (5) @(negedge iCLK);
    obs_addr.delete(); obs_data.delete();
    make_frame(3, 1'b0);
    send_txq();
    compare_state("post_rst");

    // Randomised frames, some with a corrupted checksum.
    for (int f = 0; f < 12; f++) begin
      make_frame($urandom_range(1, 4), $urandom_range(0, 3) == 0);
      send_txq();
      compare_state($sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
